// File: rtl/downscaler_2x2.sv
// rtl/downscaler_2x2.sv - 2x2 box-filter downscaler for 12-bit RGB444 pixel streams.
// The horizontal pair sum of each even line is parked in a half-width line buffer.
// The pair sum of the following odd line is added to it and divided by four.
module downscaler_2x2 #(
  parameter int IN_W = 640,
  parameter int IN_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_data,
  input  logic        in_sof,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_data,
  output logic        out_sof,
  output logic        out_eol
);

  localparam int XW = $clog2(IN_W);
  localparam int YW = (IN_H > 2) ? $clog2(IN_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IN_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IN_H - 1);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t          state, state_nxt;
  logic [XW-1:0]   x, x_nxt, ex;
  logic [YW-1:0]   y, y_nxt, ey;
  logic [11:0]     held;
  logic [14:0]     line_buf [IN_W/2];
  logic [14:0]     lb_rd;
  logic [4:0]      h_r, h_g, h_b;
  logic [5:0]      v_r, v_g, v_b;
  logic            accept, take, load;

  assign in_ready = (state == WAIT_SOF) ? 1'b1 : (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  // Beats outside a frame are swallowed; an in_sof beat always restarts at (0,0).
  assign take     = accept && ((state == ACTIVE) || in_sof);
  assign ex       = in_sof ? '0 : x;
  assign ey       = in_sof ? '0 : y;
  assign load     = take && ex[0] && ey[0];

  assign lb_rd = line_buf[ex[XW-1:1]];
  assign h_r   = {1'b0, held[11:8]} + {1'b0, in_data[11:8]};
  assign h_g   = {1'b0, held[7:4]}  + {1'b0, in_data[7:4]};
  assign h_b   = {1'b0, held[3:0]}  + {1'b0, in_data[3:0]};
  assign v_r   = {1'b0, h_r} + {1'b0, lb_rd[14:10]};
  assign v_g   = {1'b0, h_g} + {1'b0, lb_rd[9:5]};
  assign v_b   = {1'b0, h_b} + {1'b0, lb_rd[4:0]};

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    if (take) begin
      state_nxt = ACTIVE;
      if (ex == X_LAST) begin
        x_nxt = '0;
        y_nxt = (ey == Y_LAST) ? '0 : ey + 1'b1;
      end else begin
        x_nxt = ex + 1'b1;
        y_nxt = ey;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_SOF;
      x         <= '0;
      y         <= '0;
      held      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      if (take && !ex[0]) held <= in_data;
      // A fresh result takes priority over draining the previous one.
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= {v_r[5:2], v_g[5:2], v_b[5:2]};
        out_sof   <= (ex == X_ONE) && (ey == Y_ONE);
        out_eol   <= (ex == X_LAST);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take && ex[0] && !ey[0]) line_buf[ex[XW-1:1]] <= {h_r, h_g, h_b};
  end

endmodule

// File: tb/tb_downscaler_2x2.sv
// tb/tb_downscaler_2x2.sv - directed self-checking bench for downscaler_2x2 on an 8x4 frame.
module tb_downscaler_2x2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        in_sof;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        out_sof;
  logic        out_eol;

  int n_checks = 0;
  int n_err    = 0;

  logic [13:0] q [$];
  logic [11:0] fa [32];
  logic [11:0] fb [32];
  logic [11:0] ea [8];
  logic [11:0] eb [8];

  downscaler_2x2 #(.IN_W(8), .IN_H(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eol   (out_eol)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) q.push_back({out_sof, out_eol, out_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [11:0] d, input logic s);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input int i, input logic [11:0] d, input logic s, input logic e);
    if (i < q.size()) begin
      check($sformatf("out%0d_data", i), q[i][11:0], d);
      check($sformatf("out%0d_sof", i), q[i][13], s);
      check($sformatf("out%0d_eol", i), q[i][12], e);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      fa[i] = 12'h000;
      fb[i] = 12'h000;
    end
    fa[0]  = 12'h000; fa[1]  = 12'h111; fa[8]  = 12'h222; fa[9]  = 12'h333;
    fa[2]  = 12'hF00; fa[3]  = 12'hE00; fa[10] = 12'hF00; fa[11] = 12'hF00;
    fa[4]  = 12'h123; fa[5]  = 12'h456; fa[12] = 12'h789; fa[13] = 12'hABC;
    fa[16] = 12'h001; fa[17] = 12'h001; fa[24] = 12'h001; fa[25] = 12'h000;
    fa[18] = 12'h800;
    fa[22] = 12'h0F0; fa[23] = 12'h0F0; fa[30] = 12'h0F1; fa[31] = 12'h0F0;
    ea = '{12'h111, 12'hE00, 12'h567, 12'h000, 12'h000, 12'h200, 12'h000, 12'h0F0};
    fb[0] = 12'h444; fb[1] = 12'h888; fb[8] = 12'hCCC; fb[9] = 12'h000;
    eb = '{12'h666, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 12'h000;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_out_eol", out_eol, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Beats before the first sof are dropped; then two frames, only the first flagged.
    q.delete();
    for (int i = 0; i < 3; i++) send(12'hFFF, 1'b0);
    settle();
    check("pre_sof_count", q.size(), 0);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 32; i++) send(12'hFFF, (f == 0) && (i == 0));
    settle();
    check("white_count", q.size(), 16);
    for (int i = 0; i < 16; i++) check_out(i, 12'hFFF, (i % 8) == 0, (i % 4) == 3);

    // Averaging with floor on hand-built blocks.
    q.delete();
    for (int i = 0; i < 32; i++) send(fa[i], i == 0);
    settle();
    check("avg_count", q.size(), 8);
    for (int i = 0; i < 8; i++) check_out(i, ea[i], i == 0, (i % 4) == 3);

    // Output backpressure stalls the input side.
    q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(fa[i], i == 0);
    check("stall_loaded", out_valid, 1);
    in_valid = 1'b1;
    in_data  = fa[10];
    in_sof   = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_data", out_data, 12'h111);
      check("stall_out_sof", out_sof, 1);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 11; i < 32; i++) send(fa[i], 1'b0);
    settle();
    check("stall_count", q.size(), 8);
    for (int i = 0; i < 8; i++) check_out(i, ea[i], i == 0, (i % 4) == 3);

    // sof arriving at (3,2) restarts the frame.
    q.delete();
    for (int i = 0; i <= 18; i++) send(fa[i], i == 0);
    for (int i = 0; i < 32; i++) send(fb[i], i == 0);
    settle();
    check("resof_count", q.size(), 12);
    for (int i = 0; i < 4; i++) check_out(i, ea[i], i == 0, i == 3);
    for (int i = 0; i < 8; i++) check_out(4 + i, eb[i], i == 0, (i % 4) == 3);

    // Asynchronous reset mid-frame with a pending output.
    q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(fa[i], i == 0);
    check("prerst_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_sof", out_sof, 0);
    check("arst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(12'hFFF, 1'b0);
    settle();
    check("postrst_count", q.size(), 0);
    q.delete();
    for (int i = 0; i < 32; i++) send(12'hFFF, i == 0);
    settle();
    check("recover_count", q.size(), 8);
    for (int i = 0; i < 8; i++) check_out(i, 12'hFFF, i == 0, (i % 4) == 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/downscaler_2x2.md
DOWNSCALER_2X2 -- requirements
Module: downscaler_2x2

Interface
REQ-001 SHALL provide parameter IN_W, default 640: input active pixels per line; even, >= 4.
REQ-002 SHALL provide parameter IN_H, default 480: input active lines per frame; even, >= 2.
REQ-003 SHALL provide port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL provide port rst_n, input, 1: reset, asynchronous assertion, active-low.
REQ-005 SHALL provide port in_valid, input, 1: in_data holds a pixel.
REQ-006 SHALL provide port in_ready, output, 1: block accepts the pixel this cycle.
REQ-007 SHALL provide port in_data, input, 12: pixel {R[11:8], G[7:4], B[3:0]}.
REQ-008 SHALL provide port in_sof, input, 1: in_data is pixel (0,0) of a frame.
REQ-009 SHALL provide port out_valid, output, 1: out_data holds a downscaled pixel.
REQ-010 SHALL provide port out_ready, input, 1: consumer takes the output pixel this cycle.
REQ-011 SHALL provide port out_data, output, 12: downscaled pixel, same RGB packing.
REQ-012 SHALL provide port out_sof, output, 1: out_data is output pixel (0,0).
REQ-013 SHALL provide port out_eol, output, 1: out_data is output pixel x = IN_W/2-1.

Function
REQ-014 SHALL count an input beat as accepted only on in_valid && in_ready at a rising clk edge.
REQ-015 SHALL implement state WAIT_SOF: in_ready=1, accepted beats discarded, except beat with in_sof=1 processed as (0,0), then move to ACTIVE.
REQ-016 SHALL in ACTIVE drive in_ready = !out_valid || out_ready.
REQ-017 SHALL keep input counters x (0..IN_W-1) and y (0..IN_H-1): x increments per accepted beat; at IN_W-1 x wraps to 0 and y increments; at (IN_W-1, IN_H-1) both wrap to 0, state stays ACTIVE.
REQ-018 SHALL treat any accepted in_sof=1 beat in ACTIVE as (0,0): counters forced, held even pixel and partial row discarded, pending output register unaffected.
REQ-019 SHALL on even x latch the pixel's three 4-bit channels.
REQ-020 SHALL on odd x form per-channel 5-bit horizontal sum (latched even + current), no truncation.
REQ-021 SHALL on even y write the 15-bit horizontal-sum triple to line buffer entry x>>1 (IN_W/2 entries; contents not reset).
REQ-022 SHALL on odd y, odd x add line buffer entry x>>1 to the current horizontal sum, per channel 6 bits, and output channel = sum >> 2 (floor, no rounding).
REQ-023 SHALL load the output register one clk after the accepting edge of the odd-y, odd-x beat: out_valid=1, out_data, out_sof = (x==1 && y==1), out_eol = (x==IN_W-1).
REQ-024 SHALL hold out_data/out_sof/out_eol stable while out_valid && !out_ready.
REQ-025 SHALL clear out_valid after out_ready handshake unless a new result loads the same edge (simultaneous drain and load: new result wins, out_valid stays 1).
REQ-026 SHALL produce exactly (IN_W/2)*(IN_H/2) outputs per uninterrupted frame, in raster order.

Reset
REQ-027 SHALL on rst_n=0 immediately force out_valid=0, out_data=0, out_sof=0, out_eol=0, x=0, y=0, state WAIT_SOF, held pixel cleared.
REQ-028 SHALL after reset release (or reset mid-frame) ignore all beats until the next accepted in_sof=1; pending output lost.

Verification
REQ-029 SHALL cover: full 640x480 frame all 0xFFF, out_ready=1 -> 76800 outputs all 0xFFF, out_sof on first only, out_eol every 320th.
REQ-030 SHALL cover: row0 pixels 0x000,0x111; row1 pixels 0x222,0x333 at x=0,1 -> first out_data 0x111 (sum 6 >> 2).
REQ-031 SHALL cover: row0 0xF00,0xE00; row1 0xF00,0xF00 -> out_data 0xE00 (59 >> 2 = 14, floor).
REQ-032 SHALL cover: out_ready=0 for 10 cycles with out_valid=1 -> out_data stable, in_ready=0, zero beats accepted; out_ready=1 -> drain, in_ready=1 same cycle.
REQ-033 SHALL cover: in_sof beat at input (100,7) -> counters restart; next output asserts out_sof and equals 2x2 average of new frame's first block.
REQ-034 SHALL cover: rst_n pulsed low mid-frame with out_valid=1 -> out_valid=0 without clk edge; beats before next in_sof produce no output.
